crack_result_collector: RTL and testbench

- Downstream stage of the parallel password_cracker worker array.
- Consumes each worker's found/done status and its matching guess. Arbitrates simultaneous hits and latches the winning password, worker index and elapsed cycle count.
- Broadcasts a stop to all workers and presents one result to the host side over a valid/ready handshake.
- Replaces the current shared wired found/done nets with per-worker inputs.

---
 rtl/crack_pkg.sv | 26 ++
 rtl/crack_priority_encoder.sv | 20 ++
 rtl/crack_result_collector.sv | 122 ++++++++++++
 tb/tb_crack_result_collector.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/crack_pkg.sv
// Shared constants and types for the password_cracker worker array
// and its result collector.
package crack_pkg;

  localparam int PW_W         = 32;
  localparam int CHARSET_SIZE = 36;
  localparam int NUM_WORKERS  = 9;
  localparam int RANGE_SPAN   = 4;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RUN       = 2'd1,
    FOUND     = 2'd2,
    EXHAUSTED = 2'd3
  } collector_state_t;

  // Worker i searches first-character slots [4*i, 4*i+3].
  function automatic int worker_range_from(input int i);
    return RANGE_SPAN * i;
  endfunction

  function automatic int worker_range_to(input int i);
    return RANGE_SPAN * i + RANGE_SPAN - 1;
  endfunction

endpackage

// File: rtl/crack_priority_encoder.sv
// Lowest-index-wins encoder over the per-worker found vector.
// Produces an any-set flag and the index of the lowest set bit.
module crack_priority_encoder #(
  parameter int N     = 9,
  parameter int IDX_W = 4
) (
  input  logic [N-1:0]     i_req,
  output logic             o_any,
  output logic [IDX_W-1:0] o_idx
);

  always_comb begin
    o_any = |i_req;
    o_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_req[i]) o_idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/crack_result_collector.sv
// Collects per-worker found/done status, arbitrates the winner and
// holds one result for the host behind a valid/ready handshake.
module crack_result_collector
  import crack_pkg::*;
#(
  parameter int NUM_WORKERS = crack_pkg::NUM_WORKERS,
  parameter int PW_W        = crack_pkg::PW_W,
  parameter int IDX_W       = 4,
  parameter int CYC_W       = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [NUM_WORKERS-1:0]  worker_found,
  input  logic [NUM_WORKERS-1:0]  worker_done,
  input  logic [NUM_WORKERS*PW_W-1:0] worker_guess,
  output logic                    stop_workers,
  output logic                    busy,
  output logic                    result_valid,
  input  logic                    result_ready,
  output logic                    result_found,
  output logic [PW_W-1:0]         result_password,
  output logic [IDX_W-1:0]        result_worker,
  output logic [CYC_W-1:0]        result_cycles
);

  collector_state_t r_state, w_state_nxt;

  logic [NUM_WORKERS-1:0] r_done;
  logic [CYC_W-1:0]       r_cnt;
  logic [CYC_W-1:0]       w_cnt_nxt;
  logic                   r_found;
  logic [PW_W-1:0]        r_pw;
  logic [IDX_W-1:0]       r_worker;
  logic [CYC_W-1:0]       r_cycles;

  logic                   w_any;
  logic [IDX_W-1:0]       w_idx;
  logic [PW_W-1:0]        w_guess;
  logic                   w_all_done;

  crack_priority_encoder #(
    .N     (NUM_WORKERS),
    .IDX_W (IDX_W)
  ) u_prio (
    .i_req (worker_found),
    .o_any (w_any),
    .o_idx (w_idx)
  );

  always_comb begin
    w_guess = '0;
    for (int i = 0; i < NUM_WORKERS; i++) begin
      if (w_idx == IDX_W'(i)) w_guess = worker_guess[i*PW_W +: PW_W];
    end
  end

  // Count includes the current RUN cycle and never wraps.
  assign w_cnt_nxt  = (&r_cnt) ? r_cnt : r_cnt + 1'b1;
  assign w_all_done = &(r_done | worker_done);

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:      if (start) w_state_nxt = RUN;
      RUN: begin
        if (w_any)           w_state_nxt = FOUND;
        else if (w_all_done) w_state_nxt = EXHAUSTED;
      end
      FOUND,
      EXHAUSTED: if (result_ready) w_state_nxt = IDLE;
      default:   w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state  <= IDLE;
      r_done   <= '0;
      r_cnt    <= '0;
      r_found  <= 1'b0;
      r_pw     <= '0;
      r_worker <= '0;
      r_cycles <= '0;
    end else begin
      r_state <= w_state_nxt;
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_done <= '0;
            r_cnt  <= '0;
          end
        end
        RUN: begin
          r_cnt  <= w_cnt_nxt;
          r_done <= r_done | worker_done;
          if (w_any) begin
            r_found  <= 1'b1;
            r_pw     <= w_guess;
            r_worker <= w_idx;
            r_cycles <= w_cnt_nxt;
          end else if (w_all_done) begin
            r_found  <= 1'b0;
            r_pw     <= '0;
            r_worker <= '0;
            r_cycles <= w_cnt_nxt;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy            = (r_state == RUN);
  assign stop_workers    = (r_state != RUN);
  assign result_valid    = (r_state == FOUND) || (r_state == EXHAUSTED);
  assign result_found    = r_found;
  assign result_password = r_pw;
  assign result_worker   = r_worker;
  assign result_cycles   = r_cycles;

endmodule

// File: tb/tb_crack_result_collector.sv
// Directed self-checking bench for crack_result_collector.
module tb_crack_result_collector;

  localparam int NW    = 9;
  localparam int PW    = 32;
  localparam int IW    = 4;
  localparam int CW    = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [NW-1:0]     worker_found;
  logic [NW-1:0]     worker_done;
  logic [NW*PW-1:0]  worker_guess;
  logic              stop_workers;
  logic              busy;
  logic              result_valid;
  logic              result_ready;
  logic              result_found;
  logic [PW-1:0]     result_password;
  logic [IW-1:0]     result_worker;
  logic [CW-1:0]     result_cycles;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  crack_result_collector #(
    .NUM_WORKERS (NW),
    .PW_W        (PW),
    .IDX_W       (IW),
    .CYC_W       (CW)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .worker_found    (worker_found),
    .worker_done     (worker_done),
    .worker_guess    (worker_guess),
    .stop_workers    (stop_workers),
    .busy            (busy),
    .result_valid    (result_valid),
    .result_ready    (result_ready),
    .result_found    (result_found),
    .result_password (result_password),
    .result_worker   (result_worker),
    .result_cycles   (result_cycles)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_guess(input int i, input logic [PW-1:0] v);
    worker_guess[i*PW +: PW] = v;
  endtask

  task automatic check_result(input string tag, input logic f,
                              input logic [PW-1:0] pw,
                              input logic [IW-1:0] w,
                              input logic [CW-1:0] c);
    check({tag, "_valid"}, 64'(result_valid), 64'(1'b1));
    check({tag, "_found"}, 64'(result_found), 64'(f));
    check({tag, "_pw"},    64'(result_password), 64'(pw));
    check({tag, "_worker"}, 64'(result_worker), 64'(w));
    check({tag, "_cycles"}, 64'(result_cycles), 64'(c));
    check({tag, "_stop"},  64'(stop_workers), 64'(1'b1));
    check({tag, "_busy"},  64'(busy), 64'(1'b0));
  endtask

  task automatic begin_search();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    rst          = 1'b0;
    start        = 1'b0;
    worker_found = '0;
    worker_done  = '0;
    worker_guess = '0;
    result_ready = 1'b0;

    // Reset state
    step();
    step();
    check("rst_valid",  64'(result_valid), 64'(0));
    check("rst_found",  64'(result_found), 64'(0));
    check("rst_pw",     64'(result_password), 64'(0));
    check("rst_worker", 64'(result_worker), 64'(0));
    check("rst_cycles", 64'(result_cycles), 64'(0));
    check("rst_stop",   64'(stop_workers), 64'(1));
    check("rst_busy",   64'(busy), 64'(0));
    rst = 1'b1;

    // Found in IDLE is ignored
    worker_found = 9'h010;
    step();
    check("idle_ign_valid", 64'(result_valid), 64'(0));
    check("idle_ign_busy",  64'(busy), 64'(0));
    worker_found = '0;

    // Single hit: worker 5 at RUN cycle 7
    begin_search();
    check("run_busy", 64'(busy), 64'(1));
    check("run_stop", 64'(stop_workers), 64'(0));
    for (int k = 1; k < 7; k++) step();
    check("run_nores", 64'(result_valid), 64'(0));
    worker_found = 9'h020;
    set_guess(5, 32'h61626364);
    step();
    worker_found = '0;
    check_result("single", 1'b1, 32'h61626364, 4'd5, 32'd7);
    result_ready = 1'b1;
    step();
    result_ready = 1'b0;
    check("single_acc_valid", 64'(result_valid), 64'(0));
    check("single_acc_stop",  64'(stop_workers), 64'(1));

    // Simultaneous hits, ready high on the edge the result appears
    begin_search();
    worker_found = 9'h044;
    set_guess(2, 32'h11112222);
    set_guess(6, 32'h66667777);
    result_ready = 1'b1;
    step();
    worker_found = '0;
    check_result("simul", 1'b1, 32'h11112222, 4'd2, 32'd1);
    step();
    result_ready = 1'b0;
    check("simul_acc_valid", 64'(result_valid), 64'(0));
    check("simul_acc_busy",  64'(busy), 64'(0));

    // Exhaustion: done pulses one per worker over cycles 3..11
    begin_search();
    for (int c = 1; c <= 11; c++) begin
      worker_done = (c >= 3) ? (NW'(1) << (c - 3)) : '0;
      if (c == 10)
        check("exh_pending", 64'(result_valid), 64'(0));
      step();
    end
    worker_done = '0;
    check_result("exh", 1'b0, 32'h0, 4'd0, 32'd11);
    result_ready = 1'b1;
    step();
    result_ready = 1'b0;
    check("exh_acc_valid", 64'(result_valid), 64'(0));

    // Found and final done together: found wins
    begin_search();
    worker_done = 9'h0FF;
    step();
    check("fd_pending", 64'(result_valid), 64'(0));
    worker_done  = 9'h100;
    worker_found = 9'h001;
    set_guess(0, 32'hDEADBEEF);
    step();
    worker_done  = '0;
    worker_found = '0;
    check_result("fd", 1'b1, 32'hDEADBEEF, 4'd0, 32'd2);
    result_ready = 1'b1;
    step();
    result_ready = 1'b0;

    // Own found honoured despite own done in same cycle
    begin_search();
    worker_done  = 9'h008;
    worker_found = 9'h008;
    set_guess(3, 32'h33334444);
    step();
    worker_done  = '0;
    worker_found = '0;
    check_result("own", 1'b1, 32'h33334444, 4'd3, 32'd1);

    // Backpressure while worker inputs toggle
    for (int k = 0; k < 10; k++) begin
      worker_found = (k % 2 == 0) ? 9'h1FF : 9'h001;
      worker_done  = (k % 2 == 0) ? 9'h000 : 9'h1FF;
      set_guess(0, 32'hA0A0A000 + 32'(k));
      set_guess(3, 32'hB0B0B000 + 32'(k));
      step();
      check("bp_valid",  64'(result_valid), 64'(1));
      check("bp_pw",     64'(result_password), 64'(32'h33334444));
      check("bp_worker", 64'(result_worker), 64'(4'd3));
      check("bp_cycles", 64'(result_cycles), 64'(32'd1));
    end
    worker_found = '0;
    worker_done  = '0;
    result_ready = 1'b1;
    start        = 1'b1;
    step();
    result_ready = 1'b0;
    start        = 1'b0;
    check("bp_acc_valid", 64'(result_valid), 64'(0));
    check("bp_acc_busy",  64'(busy), 64'(0));
    step();
    check("bp_start_ign", 64'(busy), 64'(0));

    // Reset mid-search at RUN cycle 4
    begin_search();
    for (int k = 1; k < 4; k++) step();
    rst = 1'b0;
    step();
    rst = 1'b1;
    check("mid_rst_busy",   64'(busy), 64'(0));
    check("mid_rst_valid",  64'(result_valid), 64'(0));
    check("mid_rst_cycles", 64'(result_cycles), 64'(0));
    check("mid_rst_pw",     64'(result_password), 64'(0));
    begin_search();
    step();
    step();
    check("mid_rst_nores", 64'(result_valid), 64'(0));
    worker_found = 9'h080;
    set_guess(7, 32'h77778888);
    step();
    worker_found = '0;
    check_result("restart", 1'b1, 32'h77778888, 4'd7, 32'd3);
    result_ready = 1'b1;
    step();
    result_ready = 1'b0;
    check("restart_acc", 64'(result_valid), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
